// File: rtl/eth_idma_xfer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : eth_idma_xfer_sched
//  Description : Round-robin scheduler of TX/RX ethernet DMA descriptors onto
//                a single iDMA request port, with an in-order owner FIFO
//                that routes each iDMA completion back to its requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_idma_xfer_sched #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned TFLenWidth     = 32,
    parameter int unsigned ProtWidth      = 3,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    // TX requester
    input  logic                                 tx_req_valid_i,
    output logic                                 tx_req_ready_o,
    input  logic [AddrWidth-1:0]                 tx_src_addr_i,
    input  logic [AddrWidth-1:0]                 tx_dst_addr_i,
    input  logic [TFLenWidth-1:0]                tx_len_i,
    input  logic [ProtWidth-1:0]                 tx_src_prot_i,
    input  logic [ProtWidth-1:0]                 tx_dst_prot_i,
    output logic                                 tx_rsp_valid_o,
    input  logic                                 tx_rsp_ready_i,
    output logic                                 tx_rsp_error_o,
    // RX requester
    input  logic                                 rx_req_valid_i,
    output logic                                 rx_req_ready_o,
    input  logic [AddrWidth-1:0]                 rx_src_addr_i,
    input  logic [AddrWidth-1:0]                 rx_dst_addr_i,
    input  logic [TFLenWidth-1:0]                rx_len_i,
    input  logic [ProtWidth-1:0]                 rx_src_prot_i,
    input  logic [ProtWidth-1:0]                 rx_dst_prot_i,
    output logic                                 rx_rsp_valid_o,
    input  logic                                 rx_rsp_ready_i,
    output logic                                 rx_rsp_error_o,
    // iDMA frontend
    output logic                                 idma_req_valid_o,
    input  logic                                 idma_req_ready_i,
    output logic [AddrWidth-1:0]                 idma_src_addr_o,
    output logic [AddrWidth-1:0]                 idma_dst_addr_o,
    output logic [TFLenWidth-1:0]                idma_len_o,
    output logic [ProtWidth-1:0]                 idma_src_prot_o,
    output logic [ProtWidth-1:0]                 idma_dst_prot_o,
    input  logic                                 idma_rsp_valid_i,
    output logic                                 idma_rsp_ready_o,
    input  logic                                 idma_rsp_error_i,
    // status
    output logic                                 busy_o,
    output logic [$clog2(MaxOutstanding):0]      outstanding_o,
    output logic                                 spurious_rsp_o
);

    localparam int unsigned c_PTR_W = $clog2(MaxOutstanding);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MaxOutstanding);

    // holding register toward iDMA
    logic                      r_hold_valid;
    logic [AddrWidth-1:0]      r_src_addr;
    logic [AddrWidth-1:0]      r_dst_addr;
    logic [TFLenWidth-1:0]     r_len;
    logic [ProtWidth-1:0]      r_src_prot;
    logic [ProtWidth-1:0]      r_dst_prot;

    // arbitration and ownership tracking
    logic                      r_rr_rx;      // 1: RX wins the next tie
    logic [MaxOutstanding-1:0] r_owner;      // 0 = TX, 1 = RX
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]        r_count;
    logic                      r_spurious;

    logic w_fifo_empty;
    logic w_head_rx;
    logic w_head_ready;
    logic w_pop;
    logic w_slot_free;
    logic w_can_grant;
    logic w_grant_tx;
    logic w_grant_rx;
    logic w_push;

    // Counter equals FIFO occupancy, so it doubles as the empty flag.
    assign w_fifo_empty = (r_count == '0);
    assign w_head_rx    = r_owner[r_rd_ptr];
    assign w_head_ready = w_head_rx ? rx_rsp_ready_i : tx_rsp_ready_i;
    assign w_pop        = !w_fifo_empty && idma_rsp_valid_i && w_head_ready;

    // A completion retiring this cycle frees its slot for a same-cycle grant.
    assign w_slot_free  = (r_count < c_MAX) || w_pop;
    assign w_can_grant  = (!r_hold_valid || idma_req_ready_i) && w_slot_free;
    assign w_grant_tx   = w_can_grant && tx_req_valid_i && (!rx_req_valid_i || !r_rr_rx);
    assign w_grant_rx   = w_can_grant && rx_req_valid_i && (!tx_req_valid_i ||  r_rr_rx);
    assign w_push       = w_grant_tx || w_grant_rx;

    // Handshake outputs are forced low while reset is asserted so the block
    // looks idle to both sides immediately, not only after the next edge.
    assign tx_req_ready_o   = rst_ni && w_grant_tx;
    assign rx_req_ready_o   = rst_ni && w_grant_rx;
    assign tx_rsp_valid_o   = rst_ni && !w_fifo_empty && !w_head_rx && idma_rsp_valid_i;
    assign rx_rsp_valid_o   = rst_ni && !w_fifo_empty &&  w_head_rx && idma_rsp_valid_i;
    assign tx_rsp_error_o   = rst_ni && !w_fifo_empty && !w_head_rx && idma_rsp_error_i;
    assign rx_rsp_error_o   = rst_ni && !w_fifo_empty &&  w_head_rx && idma_rsp_error_i;
    // With no owner recorded the response is drained unconditionally.
    assign idma_rsp_ready_o = rst_ni && (w_fifo_empty || w_head_ready);

    assign idma_req_valid_o = r_hold_valid;
    assign idma_src_addr_o  = r_src_addr;
    assign idma_dst_addr_o  = r_dst_addr;
    assign idma_len_o       = r_len;
    assign idma_src_prot_o  = r_src_prot;
    assign idma_dst_prot_o  = r_dst_prot;
    assign busy_o           = (r_count != '0);
    assign outstanding_o    = r_count;
    assign spurious_rsp_o   = r_spurious;

    // Holding register: load the winner, otherwise empty once iDMA accepts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_valid <= 1'b0;
            r_src_addr   <= '0;
            r_dst_addr   <= '0;
            r_len        <= '0;
            r_src_prot   <= '0;
            r_dst_prot   <= '0;
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_src_addr   <= w_grant_rx ? rx_src_addr_i : tx_src_addr_i;
            r_dst_addr   <= w_grant_rx ? rx_dst_addr_i : tx_dst_addr_i;
            r_len        <= w_grant_rx ? rx_len_i      : tx_len_i;
            r_src_prot   <= w_grant_rx ? rx_src_prot_i : tx_src_prot_i;
            r_dst_prot   <= w_grant_rx ? rx_dst_prot_i : tx_dst_prot_i;
        end else if (idma_req_ready_i) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Round-robin pointer always moves to the requester that just lost out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_rx <= 1'b0;
        end else if (w_push) begin
            r_rr_rx <= w_grant_tx;
        end
    end

    // Owner FIFO storage; a push may overwrite the entry popped this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner <= '0;
        end else if (w_push) begin
            r_owner[r_wr_ptr] <= w_grant_rx;
        end
    end

    // FIFO pointers wrap naturally; the counter spans 0..MaxOutstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for completions that arrive with no recorded owner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_spurious <= 1'b0;
        end else if (idma_rsp_valid_i && w_fifo_empty) begin
            r_spurious <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_idma_xfer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_idma_xfer_sched
//  Description : Directed self-checking bench for eth_idma_xfer_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eth_idma_xfer_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        tx_req_valid_i, tx_req_ready_o;
    logic [63:0] tx_src_addr_i, tx_dst_addr_i;
    logic [31:0] tx_len_i;
    logic [2:0]  tx_src_prot_i, tx_dst_prot_i;
    logic        tx_rsp_valid_o, tx_rsp_ready_i, tx_rsp_error_o;
    logic        rx_req_valid_i, rx_req_ready_o;
    logic [63:0] rx_src_addr_i, rx_dst_addr_i;
    logic [31:0] rx_len_i;
    logic [2:0]  rx_src_prot_i, rx_dst_prot_i;
    logic        rx_rsp_valid_o, rx_rsp_ready_i, rx_rsp_error_o;
    logic        idma_req_valid_o, idma_req_ready_i;
    logic [63:0] idma_src_addr_o, idma_dst_addr_o;
    logic [31:0] idma_len_o;
    logic [2:0]  idma_src_prot_o, idma_dst_prot_o;
    logic        idma_rsp_valid_i, idma_rsp_ready_o, idma_rsp_error_i;
    logic        busy_o;
    logic [2:0]  outstanding_o;
    logic        spurious_rsp_o;

    int n_checks = 0;
    int n_pass   = 0;

    eth_idma_xfer_sched #(
        .AddrWidth(64), .TFLenWidth(32), .ProtWidth(3), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .tx_req_valid_i(tx_req_valid_i), .tx_req_ready_o(tx_req_ready_o),
        .tx_src_addr_i(tx_src_addr_i), .tx_dst_addr_i(tx_dst_addr_i),
        .tx_len_i(tx_len_i), .tx_src_prot_i(tx_src_prot_i), .tx_dst_prot_i(tx_dst_prot_i),
        .tx_rsp_valid_o(tx_rsp_valid_o), .tx_rsp_ready_i(tx_rsp_ready_i),
        .tx_rsp_error_o(tx_rsp_error_o),
        .rx_req_valid_i(rx_req_valid_i), .rx_req_ready_o(rx_req_ready_o),
        .rx_src_addr_i(rx_src_addr_i), .rx_dst_addr_i(rx_dst_addr_i),
        .rx_len_i(rx_len_i), .rx_src_prot_i(rx_src_prot_i), .rx_dst_prot_i(rx_dst_prot_i),
        .rx_rsp_valid_o(rx_rsp_valid_o), .rx_rsp_ready_i(rx_rsp_ready_i),
        .rx_rsp_error_o(rx_rsp_error_o),
        .idma_req_valid_o(idma_req_valid_o), .idma_req_ready_i(idma_req_ready_i),
        .idma_src_addr_o(idma_src_addr_o), .idma_dst_addr_o(idma_dst_addr_o),
        .idma_len_o(idma_len_o), .idma_src_prot_o(idma_src_prot_o),
        .idma_dst_prot_o(idma_dst_prot_o),
        .idma_rsp_valid_i(idma_rsp_valid_i), .idma_rsp_ready_o(idma_rsp_ready_o),
        .idma_rsp_error_i(idma_rsp_error_i),
        .busy_o(busy_o), .outstanding_o(outstanding_o), .spurious_rsp_o(spurious_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        tx_req_valid_i = 0; tx_src_addr_i = '0; tx_dst_addr_i = '0; tx_len_i = '0;
        tx_src_prot_i = '0; tx_dst_prot_i = '0; tx_rsp_ready_i = 1'b1;
        rx_req_valid_i = 0; rx_src_addr_i = '0; rx_dst_addr_i = '0; rx_len_i = '0;
        rx_src_prot_i = '0; rx_dst_prot_i = '0; rx_rsp_ready_i = 1'b1;
        idma_req_ready_i = 1'b1; idma_rsp_valid_i = 1'b0; idma_rsp_error_i = 1'b0;

        // ---------------- reset state ----------------
        #3;
        check("rst_req_valid",   64'(idma_req_valid_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o),    64'd0);
        check("rst_busy",        64'(busy_o),           64'd0);
        check("rst_spurious",    64'(spurious_rsp_o),   64'd0);
        check("rst_rsp_ready",   64'(idma_rsp_ready_o), 64'd0);
        tick(); tick();
        rst_ni = 1'b1;

        // ---------------- single TX descriptor ----------------
        tx_src_addr_i = 64'h0; tx_dst_addr_i = 64'h2070_9800_1032; tx_len_i = 32'd8;
        tx_src_prot_i = 3'd0;  tx_dst_prot_i = 3'd5;  tx_req_valid_i = 1'b1;
        #1;
        check("t1_tx_ready",   64'(tx_req_ready_o),   64'd1);
        check("t1_rx_ready",   64'(rx_req_ready_o),   64'd0);
        check("t1_valid_n",    64'(idma_req_valid_o), 64'd0);
        tick();
        tx_req_valid_i = 1'b0;
        #1;
        check("t1_valid_n1",   64'(idma_req_valid_o), 64'd1);
        check("t1_src",        idma_src_addr_o,       64'h0);
        check("t1_dst",        idma_dst_addr_o,       64'h2070_9800_1032);
        check("t1_len",        64'(idma_len_o),       64'd8);
        check("t1_sprot",      64'(idma_src_prot_o),  64'd0);
        check("t1_dprot",      64'(idma_dst_prot_o),  64'd5);
        check("t1_outst",      64'(outstanding_o),    64'd1);
        check("t1_busy",       64'(busy_o),           64'd1);
        tick();
        check("t1_drained",    64'(idma_req_valid_o), 64'd0);
        idma_rsp_valid_i = 1'b1;
        #1;
        check("t1_tx_rsp",     64'(tx_rsp_valid_o),   64'd1);
        check("t1_rx_rsp",     64'(rx_rsp_valid_o),   64'd0);
        check("t1_tx_err",     64'(tx_rsp_error_o),   64'd0);
        check("t1_rsp_ready",  64'(idma_rsp_ready_o), 64'd1);
        tick();
        idma_rsp_valid_i = 1'b0;
        check("t1_busy_end",   64'(busy_o),           64'd0);
        check("t1_outst_end",  64'(outstanding_o),    64'd0);

        // Reset pulse between edges restores the TX-first tie break.
        rst_ni = 1'b0; #1; rst_ni = 1'b1;

        // ---------------- alternating grants up to the limit ----------------
        tx_len_i = 32'd100; rx_len_i = 32'd200;
        tx_req_valid_i = 1'b1; rx_req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_tx_grant", 64'(tx_req_ready_o), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("t2_rx_grant", 64'(rx_req_ready_o), (i % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            check("t2_len",   64'(idma_len_o),    (i % 2 == 0) ? 64'd100 : 64'd200);
            check("t2_outst", 64'(outstanding_o), 64'(i + 1));
        end
        #1;
        check("t2_full_tx", 64'(tx_req_ready_o), 64'd0);
        check("t2_full_rx", 64'(rx_req_ready_o), 64'd0);
        tick();
        tx_req_valid_i = 1'b0; rx_req_valid_i = 1'b0;
        check("t2_hold_empty", 64'(idma_req_valid_o), 64'd0);
        check("t2_outst4",     64'(outstanding_o),    64'd4);

        // ---------------- response + grant in the same cycle at full ----------------
        tx_len_i = 32'd300; tx_req_valid_i = 1'b1; idma_rsp_valid_i = 1'b1;
        #1;
        check("t4_tx_rsp",   64'(tx_rsp_valid_o), 64'd1);
        check("t4_rx_rsp",   64'(rx_rsp_valid_o), 64'd0);
        check("t4_tx_grant", 64'(tx_req_ready_o), 64'd1);
        tick();
        tx_req_valid_i = 1'b0;
        check("t4_outst",    64'(outstanding_o),    64'd4);
        check("t4_len",      64'(idma_len_o),       64'd300);
        check("t4_valid",    64'(idma_req_valid_o), 64'd1);

        // ---------------- RX head with requester back-pressure ----------------
        tx_rsp_ready_i = 1'b0; rx_rsp_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t5_rsp_ready_lo", 64'(idma_rsp_ready_o), 64'd0);
            check("t5_rx_rsp",       64'(rx_rsp_valid_o),   64'd1);
            check("t5_tx_rsp",       64'(tx_rsp_valid_o),   64'd0);
            tick();
            check("t5_outst_hold",   64'(outstanding_o),    64'd4);
        end
        rx_rsp_ready_i = 1'b1; idma_rsp_error_i = 1'b1;
        #1;
        check("t5_rsp_ready_hi", 64'(idma_rsp_ready_o), 64'd1);
        check("t5_rx_err",       64'(rx_rsp_error_o),   64'd1);
        check("t5_tx_err",       64'(tx_rsp_error_o),   64'd0);
        tick();
        idma_rsp_error_i = 1'b0;
        check("t5_one_pop",      64'(outstanding_o),    64'd3);
        tx_rsp_ready_i = 1'b1;
        // Remaining owners in order: TX, RX, TX (the last pushed at full).
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t4_order_tx", 64'(tx_rsp_valid_o), (j == 1) ? 64'd0 : 64'd1);
            check("t4_order_rx", 64'(rx_rsp_valid_o), (j == 1) ? 64'd1 : 64'd0);
            tick();
            check("t4_order_cnt", 64'(outstanding_o), 64'(2 - j));
        end
        idma_rsp_valid_i = 1'b0;
        check("t4_busy_end", 64'(busy_o), 64'd0);

        // ---------------- iDMA stall with a descriptor held ----------------
        idma_req_ready_i = 1'b0;
        tx_src_addr_i = 64'hA000; tx_len_i = 32'h11; tx_req_valid_i = 1'b1;
        #1;
        check("t3_first_grant", 64'(tx_req_ready_o), 64'd1);
        tick();
        tx_src_addr_i = 64'hB000; tx_len_i = 32'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_valid", 64'(idma_req_valid_o), 64'd1);
            check("t3_stall_src",   idma_src_addr_o,       64'hA000);
            check("t3_stall_len",   64'(idma_len_o),       64'h11);
            check("t3_no_ack",      64'(tx_req_ready_o),   64'd0);
            tick();
        end
        idma_req_ready_i = 1'b1;
        rx_src_addr_i = 64'hC000; rx_len_i = 32'h33; rx_req_valid_i = 1'b1;
        #1;
        check("t3_rx_grant", 64'(rx_req_ready_o), 64'd1);
        check("t3_tx_wait",  64'(tx_req_ready_o), 64'd0);
        tick();
        rx_req_valid_i = 1'b0;
        #1;
        check("t3_rx_len",   64'(idma_len_o),     64'h33);
        check("t3_tx_grant", 64'(tx_req_ready_o), 64'd1);
        tick();
        tx_req_valid_i = 1'b0;
        check("t3_tx_len",   64'(idma_len_o),     64'h22);
        check("t3_outst",    64'(outstanding_o),  64'd3);
        tick();
        idma_rsp_valid_i = 1'b1;
        tick(); tick(); tick();
        idma_rsp_valid_i = 1'b0;
        check("t3_flushed",  64'(outstanding_o),  64'd0);

        // ---------------- spurious response ----------------
        idma_rsp_valid_i = 1'b1;
        #1;
        check("t6_drain",      64'(idma_rsp_ready_o), 64'd1);
        check("t6_tx_rsp",     64'(tx_rsp_valid_o),   64'd0);
        check("t6_rx_rsp",     64'(rx_rsp_valid_o),   64'd0);
        check("t6_flag_pre",   64'(spurious_rsp_o),   64'd0);
        tick();
        idma_rsp_valid_i = 1'b0;
        check("t6_flag_set",   64'(spurious_rsp_o),   64'd1);
        tick();
        check("t6_flag_stick", 64'(spurious_rsp_o),   64'd1);
        check("t6_outst",      64'(outstanding_o),    64'd0);

        // ---------------- asynchronous reset mid-traffic ----------------
        tx_src_addr_i = 64'hD000; tx_req_valid_i = 1'b1;
        tick();
        idma_req_ready_i = 1'b0; idma_rsp_valid_i = 1'b1;
        #1;
        check("t7_pre_busy",  64'(busy_o),         64'd1);
        check("t7_pre_rsp",   64'(tx_rsp_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("t7_req_valid", 64'(idma_req_valid_o), 64'd0);
        check("t7_src",       idma_src_addr_o,       64'h0);
        check("t7_busy",      64'(busy_o),           64'd0);
        check("t7_outst",     64'(outstanding_o),    64'd0);
        check("t7_spurious",  64'(spurious_rsp_o),   64'd0);
        check("t7_tx_ready",  64'(tx_req_ready_o),   64'd0);
        check("t7_tx_rsp",    64'(tx_rsp_valid_o),   64'd0);
        check("t7_rsp_ready", 64'(idma_rsp_ready_o), 64'd0);
        tx_req_valid_i = 1'b0; idma_rsp_valid_i = 1'b0; idma_req_ready_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_idma_xfer_sched.md
Name: eth_idma_xfer_sched

Overview:
- Schedules ethernet DMA transfers from two requesters, the TX and RX channel register files, onto one shared iDMA frontend request/response port.
- Arbitrates round-robin between the two requesters and registers the winning descriptor toward iDMA.
- Tracks the owner of every in-flight transfer in an in-order FIFO and routes each iDMA response back to the requester that issued it.
- Sits between the eth_idma register configuration logic and the iDMA backend inside the ethernet iDMA wrapper.

Parameters:
- AddrWidth, 64, width of source/destination addresses.
- TFLenWidth, 32, width of transfer length in bytes.
- ProtWidth, 3, width of protocol selector fields.
- MaxOutstanding, 4, max transfers granted but not yet responded (power of two, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- tx_req_valid_i  in  1  TX descriptor valid.
- tx_req_ready_o  out  1  TX descriptor accepted.
- tx_src_addr_i, tx_dst_addr_i  in  AddrWidth  TX addresses.
- tx_len_i  in  TFLenWidth  TX length.
- tx_src_prot_i, tx_dst_prot_i  in  ProtWidth  TX protocols.
- tx_rsp_valid_o  out  1  TX completion valid.
- tx_rsp_ready_i  in  1  TX completion ready.
- tx_rsp_error_o  out  1  TX completion error.
- rx_*  same set as tx_*, for the RX requester.
- idma_req_valid_o  out  1  descriptor to iDMA valid.
- idma_req_ready_i  in  1  iDMA accepts descriptor.
- idma_src_addr_o, idma_dst_addr_o  out  AddrWidth  addresses.
- idma_len_o  out  TFLenWidth  length.
- idma_src_prot_o, idma_dst_prot_o  out  ProtWidth  protocols.
- idma_rsp_valid_i  in  1  iDMA completion valid.
- idma_rsp_ready_o  out  1  completion ready.
- idma_rsp_error_i  in  1  completion error.
- busy_o  out  1  any transfer granted and not yet completed.
- outstanding_o  out  $clog2(MaxOutstanding)+1  current in-flight count.
- spurious_rsp_o  out  1  sticky: response arrived with no owner recorded.

Behaviour:
- Reset values: all outputs 0, holding register empty, counter 0, owner FIFO empty, RR pointer = TX (TX wins the first tie).
- Holding register, one entry:
  - It can take a new descriptor when it is empty, or when it is full and idma_req_ready_i is high.
  - idma_req_valid_o = holding full. Descriptor fields are stable while valid && !ready.
- Grant condition: holding register can take a descriptor AND outstanding count < MaxOutstanding (registered count). The cycle a slot frees, it can be granted in that same cycle.
- Arbitration:
  - Only one valid → it wins.
  - Both valid → RR pointer wins, and the pointer then moves to the other requester.
  - A grant with a single valid requester also sets the pointer to the other requester.
- x_req_ready_o is combinational and high only for the granted requester in the grant cycle. A requester that is not granted is never acked.
- Latency: a descriptor granted in cycle N gives idma_req_valid_o=1 in cycle N+1, with back-to-back throughput of 1 per cycle.
- On grant, push the owner bit (0=TX, 1=RX) into the owner FIFO (depth MaxOutstanding) and increment the counter.
- Response routing:
  - FIFO head owner gets x_rsp_valid_o = idma_rsp_valid_i and x_rsp_error_o = idma_rsp_error_i. The other channel's rsp_valid_o stays 0.
  - idma_rsp_ready_o = head owner's rsp_ready_i.
  - On handshake: pop the FIFO and decrement the counter.
- Grant and response handshake in the same cycle: FIFO push and pop both happen, and the counter is unchanged.
- FIFO empty while idma_rsp_valid_i=1:
  - Set idma_rsp_ready_o=1 (drain), drive no requester valid, and set spurious_rsp_o.
  - spurious_rsp_o clears only on reset.
- Full condition: counter == MaxOutstanding → no grants. Any requests already in the holding register still drain.
- Counter width holds 0..MaxOutstanding without wrap. The FIFO pointers wrap modulo MaxOutstanding.
- busy_o = (counter != 0).
- Reset mid-operation clears all state asynchronously. Responses in flight afterwards are treated as spurious.

Test Plan:
- Single TX descriptor (src 0x0, dst 0x207098001032, len 8, prots 0/5), idma_req_ready_i=1:
  - tx_req_ready_o pulses in cycle N; idma_req_valid_o is high in N+1 with identical fields.
  - Response with error=0 → tx_rsp_valid_o=1, rx_rsp_valid_o=0; busy_o returns to 0.
- TX and RX held valid continuously, iDMA always ready, responses delayed:
  - Grants alternate TX,RX,TX,RX.
  - Grants stop after 4 (outstanding_o=4).
  - Responses return in grant order to TX,RX,TX,RX.
- idma_req_ready_i=0 for 5 cycles with a descriptor held:
  - idma_* fields stay stable.
  - No further x_req_ready_o until the descriptor is accepted.
- Response and new grant in the same cycle at outstanding_o=4:
  - outstanding_o stays 4.
  - The popped owner and the pushed owner are both correct.
- RX response with tx_rsp_ready_i=0 and rx_rsp_ready_i=0 while head owner is RX → idma_rsp_ready_o=0 until rx_rsp_ready_i=1, then one pop.
- idma_rsp_valid_i=1 with FIFO empty:
  - Drained; spurious_rsp_o=1 and stays set.
  - Assert rst_ni=0 mid-traffic → all outputs 0 immediately.
